// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types, constants and helpers for the 4x4 hex keypad scanner.
//   keypad_state_t : scanner FSM states (IDLE, WRITE, HELD)
//   snap_class_t   : classification of a 16-bit key snapshot
//   KEY_CODE_MAP   : snapshot bit index (4*col + row) -> key code (4*row + col)
//   snap_classify  : empty / single / multi classification of a snapshot
//   snap_code      : key code of the set bit in a single-key snapshot
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HELD  = 2'd2
    } keypad_state_t;

    typedef enum logic [1:0] {
        SNAP_EMPTY  = 2'd0,
        SNAP_SINGLE = 2'd1,
        SNAP_MULTI  = 2'd2
    } snap_class_t;

    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;
    localparam int NUM_DIGITS = 8;

    // Nibble i holds the key code for snapshot bit i. Snapshot bits are stored
    // column-major (bit 4*c + r), while key codes are row-major (4*r + c).
    localparam logic [63:0] KEY_CODE_MAP = 64'hFB73_EA62_D951_C840;

    function automatic snap_class_t snap_classify(input logic [15:0] snap);
        snap_class_t cls;
        if (snap == 16'h0000) begin
            cls = SNAP_EMPTY;
        end else if ((snap & (snap - 16'h0001)) == 16'h0000) begin
            cls = SNAP_SINGLE;
        end else begin
            cls = SNAP_MULTI;
        end
        return cls;
    endfunction

    function automatic logic [3:0] snap_code(input logic [15:0] snap);
        logic [3:0] code;
        code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (snap[i]) begin
                code = KEY_CODE_MAP[4*i +: 4];
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// -----------------------------------------------------------------------------
// keypad_if
// Write-side bundle from the keypad scanner to the seven-segment display.
//   num   [3:0] : key code of the last accepted key
//   sel   [2:0] : digit index for the current write
//   write       : one-cycle strobe, num/sel valid while high
//   held        : an accepted key is still down
// Modports: master (scanner drives), slave (display consumes).
// -----------------------------------------------------------------------------
interface keypad_if;
    logic [3:0] num;
    logic [2:0] sel;
    logic       write;
    logic       held;

    modport master (output num, output sel, output write, output held);
    modport slave  (input  num, input  sel, input  write, input  held);
endinterface

// File: rtl/keypad_row_sync.sv
// -----------------------------------------------------------------------------
// row_sync
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
//   clk          : system clock
//   reset_n      : asynchronous active-low reset (outputs 4'b1111 = no key)
//   rows_i [3:0] : raw keypad rows
//   rows_o [3:0] : synchronized rows
// -----------------------------------------------------------------------------
module row_sync (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] rows_i,
    output logic [3:0] rows_o
);
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;

    // Next-state for the two synchronizer stages.
    always_comb begin
        sync1_d = rows_i;
        sync2_d = sync1_q;
    end

    // Synchronizer flops; reset to "all rows released".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign rows_o = sync2_q;
endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low hex keypad, debounces whole-keypad snapshots and
// emits one write strobe per accepted key with an auto-incrementing digit.
//   clk           : system clock
//   reset_n       : asynchronous active-low reset
//   rows  [3:0]   : keypad rows, active-low, asynchronous
//   cols  [3:0]   : column drive, active-low, one bit low at a time
//   disp          : keypad_if.master (num, sel, write, held)
// Parameters: SCAN_DIV (clocks per column, >=4), DEBOUNCE_SCANS (1..15),
// REPEAT_SCANS (scans between repeat writes).
// Optional feature macro: KEYPAD_AUTOREPEAT_EN enables key autorepeat.
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 65536,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] cols,
    keypad_if.master            disp
);
    localparam int              DIV_W      = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [4:0]      DEB_N      = 5'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    logic [3:0]        rows_sync_s;
    logic [DIV_W-1:0]  dwell_q, dwell_d;
    logic [1:0]        col_q, col_d;
    logic [3:0]        cols_q, cols_d;
    logic [15:0]       snap_q, snap_d;
    logic [15:0]       prev_q, prev_d;
    logic [3:0]        stable_q, stable_d;
    keypad_state_t     state_q, state_d;
    logic [3:0]        num_q, num_d;
    logic [2:0]        sel_q, sel_d;
    logic              write_q, write_d;
    logic              held_q, held_d;
    logic              dwell_last_s, eos_s, stable_s;
    logic [15:0]       new_snap_s;
    snap_class_t       cls_s;
    logic [3:0]        code_s;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int     REP_W = $clog2(REPEAT_SCANS + 1);
    logic [REP_W-1:0]  rep_q, rep_d;
`endif

    row_sync u_row_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rows_i  (rows),
        .rows_o  (rows_sync_s)
    );

    // Column dwell timing, snapshot assembly and stable-scan counting.
    always_comb begin
        dwell_d      = dwell_q;
        col_d        = col_q;
        snap_d       = snap_q;
        prev_d       = prev_q;
        stable_d     = stable_q;
        dwell_last_s = (dwell_q == DWELL_LAST);
        eos_s        = dwell_last_s && (col_q == 2'd3);
        // new_snap_s already includes the column sampled this cycle, so at end
        // of scan it is the complete current scan.
        new_snap_s   = snap_q;
        if (dwell_last_s) begin
            new_snap_s[4*col_q +: 4] = ~rows_sync_s;
            dwell_d = '0;
            col_d   = col_q + 2'd1;
            snap_d  = new_snap_s;
        end else begin
            dwell_d = dwell_q + DIV_W'(1);
        end
        if (eos_s) begin
            prev_d = new_snap_s;
            if (new_snap_s == prev_q) begin
                stable_d = (stable_q == 4'd15) ? 4'd15 : stable_q + 4'd1;
            end else begin
                stable_d = 4'd0;
            end
        end else begin
            stable_d = stable_q;
        end
        // Stability counts the current scan, hence the +1 on the updated count.
        stable_s = (({1'b0, stable_d} + 5'd1) >= DEB_N);
        cols_d   = ~(4'b0001 << col_d);
    end

    // FSM next-state, latched key code, digit select and output strobes.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        sel_d   = sel_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif
        cls_s   = snap_classify(new_snap_s);
        code_s  = snap_code(new_snap_s);
        case (state_q)
            IDLE: begin
                if (eos_s && (cls_s == SNAP_SINGLE) && stable_s) begin
                    num_d   = code_s;
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                sel_d   = (sel_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : sel_q + 3'd1;
                state_d = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_d   = '0;
`endif
            end
            HELD: begin
                // Only a debounced full release re-arms; other keys are ignored.
                if (eos_s && (cls_s == SNAP_EMPTY) && stable_s) begin
                    state_d = IDLE;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (eos_s && (cls_s == SNAP_SINGLE) && (code_s == num_q)) begin
                    if ((int'(rep_q) + 1) >= REPEAT_SCANS) begin
                        rep_d   = '0;
                        state_d = WRITE;
                    end else begin
                        rep_d   = rep_q + REP_W'(1);
                    end
                end
                else if (eos_s) begin
                    rep_d = '0;
                end
`endif
                else begin
                    state_d = HELD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        write_d = (state_d == WRITE);
        held_d  = (state_d == HELD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell_q  <= '0;
            col_q    <= 2'd0;
            cols_q   <= 4'b1110;
            snap_q   <= 16'h0000;
            prev_q   <= 16'h0000;
            stable_q <= 4'd0;
            state_q  <= IDLE;
            num_q    <= 4'd0;
            sel_q    <= 3'd0;
            write_q  <= 1'b0;
            held_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q    <= '0;
`endif
        end else begin
            dwell_q  <= dwell_d;
            col_q    <= col_d;
            cols_q   <= cols_d;
            snap_q   <= snap_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            state_q  <= state_d;
            num_q    <= num_d;
            sel_q    <= sel_d;
            write_q  <= write_d;
            held_q   <= held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q    <= rep_d;
`endif
        end
    end

    assign cols       = cols_q;
    assign disp.num   = num_q;
    assign disp.sel   = sel_q;
    assign disp.write = write_q;
    assign disp.held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Scoreboard bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2,
// REPEAT_SCANS=3). A keypad model drives rows from cols and the pressed keys;
// expected {num, sel} pairs are queued by the stimulus and popped by a monitor
// on every write strobe.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;
    localparam int SCAN = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [15:0] key_dn;          // indexed by key code 4*row + col
    logic [6:0]  exp_q[$];        // {num, sel}
    logic [6:0]  mon_e;
    int          n_checks = 0;
    int          n_fails  = 0;
    int          lat;

    keypad_if bus ();

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .REPEAT_SCANS   (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rows    (rows),
        .cols    (cols),
        .disp    (bus.master)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row is pulled low when a pressed key sits in a driven column.
    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_dn[4*r + c] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.write === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("write_was_expected", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_num", bus.num, mon_e[6:3]);
                check("write_sel", bus.sel, mon_e[2:0]);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_write(input string name, input int budget, output int l);
        l = 0;
        while (bus.write !== 1'b1 && l < budget) begin
            @(negedge clk);
            l++;
        end
        check(name, bus.write === 1'b1, 1);
    endtask

    // Returns at the negedge in the first cycle of column 0's dwell.
    task automatic align_scan();
        int n;
        n = 0;
        while (cols !== 4'b0111 && n < 64) begin @(negedge clk); n++; end
        while (cols !== 4'b1110 && n < 64) begin @(negedge clk); n++; end
        check("scan_align", n < 64, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cols"},  cols,      4'b1110);
        check({tag, "_num"},   bus.num,   0);
        check({tag, "_sel"},   bus.sel,   0);
        check({tag, "_write"}, bus.write, 0);
        check({tag, "_held"},  bus.held,  0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        key_dn  = 16'h0000;
        cycles(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        cycles(2*SCAN);

        // Steady press of r1c2.
        key_dn[6] = 1'b1;
        exp_q.push_back({4'd6, 3'd0});
        wait_write("t1_write_seen", 200, lat);
        check("t1_latency", lat <= 3*SCAN + 3, 1);
        cycles(3);
        check("t1_sel_after", bus.sel, 1);
        check("t1_held", bus.held, 1);
        key_dn = 16'h0000;
        cycles(4*SCAN);
        check("t1_released", bus.held, 0);

        // Bounce the same key every 5 clocks for 40 clocks, then hold.
        align_scan();
        cycles(2);
        for (int i = 0; i < 8; i++) begin
            key_dn[6] = (i % 2 == 0);
            cycles(5);
        end
        key_dn[6] = 1'b1;
        exp_q.push_back({4'd6, 3'd1});
        wait_write("t2_write_seen", 200, lat);
        key_dn = 16'h0000;
        cycles(4*SCAN);

        // Ghosting pair r0c0 + r3c3 must never be accepted.
        key_dn[0]  = 1'b1;
        key_dn[15] = 1'b1;
        cycles(10*SCAN);
        check("t3_ghost_held", bus.held, 0);
        key_dn = 16'h0000;
        cycles(3*SCAN);
        key_dn[9] = 1'b1;
        exp_q.push_back({4'd9, 3'd2});
        wait_write("t3_write_seen", 200, lat);
        cycles(3);
        check("t3_held", bus.held, 1);
        key_dn = 16'h0000;
        cycles(4*SCAN);

        // Reset while HELD; key released shortly after reset deasserts.
        key_dn[5] = 1'b1;
        exp_q.push_back({4'd5, 3'd3});
        wait_write("t4_write_seen", 200, lat);
        cycles(3);
        check("t4_held_before_reset", bus.held, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t4_in_reset");
        cycles(3);
        reset_n = 1'b1;
        cycles(2);
        key_dn = 16'h0000;
        cycles(4*SCAN);
        check_reset_outputs("t4_after_release");

        // Keys 0..8: sel runs 0..7 then wraps to 0.
        for (int k = 0; k < 9; k++) begin
            key_dn[k] = 1'b1;
            exp_q.push_back({4'(k), 3'(k % 8)});
            wait_write("t5_write_seen", 200, lat);
            cycles(3);
            key_dn = 16'h0000;
            cycles(4*SCAN);
        end
        check("t5_sel_wrapped", bus.sel, 1);

        // Hold key A for 10 scans past acceptance.
        reset_n = 1'b0;
        cycles(2);
        reset_n = 1'b1;
        cycles(2*SCAN);
        key_dn[10] = 1'b1;
        exp_q.push_back({4'd10, 3'd0});
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_q.push_back({4'd10, 3'd1});
        exp_q.push_back({4'd10, 3'd2});
        exp_q.push_back({4'd10, 3'd3});
`endif
        wait_write("t6_write_seen", 200, lat);
        cycles(10*SCAN);
        key_dn = 16'h0000;
        cycles(4*SCAN);
        check("t6_held_released", bus.held, 0);

        check("all_writes_seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
